// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, S-box tables, bit-permutation index and control states.
package present_pkg;

    localparam int KEY_W = 80;
    localparam int BLK_W = 64;
    localparam int CNT_W = 5;

    // Entry n of each table sits at nibble n, so index 0 is the rightmost nibble.
    localparam logic [15:0][3:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [15:0][3:0] INV_SBOX = 64'hA970364BD21C8FE5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_ROUND,
        ST_DONE
    } state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX[x];
    endfunction

    // Encryption moves bit j to position perm_idx(j); the decryptor reads it back from there.
    function automatic logic [5:0] perm_idx(input int unsigned j);
        return (j == 63) ? 6'd63 : 6'((16 * j) % 63);
    endfunction

endpackage

// File: rtl/present80_decrypt_if.sv
// Start/done control and data bus shared by the PRESENT-80 cores of the crypto accelerator.
interface present80_decrypt_if;

    logic                           start;
    logic [present_pkg::BLK_W-1:0]  ciphertext;
    logic [present_pkg::KEY_W-1:0]  key;
    logic [present_pkg::BLK_W-1:0]  plaintext;
    logic                           busy;
    logic                           done;

    modport master (
        output start, ciphertext, key,
        input  plaintext, busy, done
    );

    modport slave (
        input  start, ciphertext, key,
        output plaintext, busy, done
    );

endinterface

// File: rtl/present_inv_sbox.sv
// PRESENT 4-bit inverse S-box, purely combinational.
module present_inv_sbox
    import present_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = inv_sbox(din);

endmodule

// File: rtl/present80_decrypt.sv
// Round-serial PRESENT-80 decryptor: expands the key forward to K_{N+1}, then runs the
// inverse rounds while unwinding the key schedule one step per clock.
module present80_decrypt
    import present_pkg::*;
#(
    parameter int NUM_ROUNDS = 31
) (
    input  logic                clk,
    input  logic                reset,
    present80_decrypt_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t             state, state_nx;
    logic [BLK_W-1:0]   data_q;
    logic [BLK_W-1:0]   pt_q;
    logic [KEY_W-1:0]   kreg_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [BLK_W-1:0]   data_pinv;
    logic [BLK_W-1:0]   data_sinv;
    logic [BLK_W-1:0]   round_data;
    logic [KEY_W-1:0]   key_fwd;
    logic [KEY_W-1:0]   key_t;
    logic [KEY_W-1:0]   key_rev;
    logic [3:0]         key_top_inv;

    // ---------------------------------------------------------------- data path
    always_comb begin
        data_pinv = '0;
        for (int j = 0; j < BLK_W; j++) begin
            data_pinv[j] = data_q[perm_idx(j)];
        end
    end

    for (genvar g = 0; g < BLK_W / 4; g++) begin : g_data_sbox
        present_inv_sbox u_inv_sbox (
            .din  (data_pinv[g*4 +: 4]),
            .dout (data_sinv[g*4 +: 4])
        );
    end

    // -------------------------------------------------------------- key path
    // Forward step: rotate left 61, S-box the top nibble, fold in the round counter.
    assign key_fwd = {sbox(kreg_q[18:15]), kreg_q[14:0], kreg_q[79:39],
                      kreg_q[38:34] ^ cnt_q, kreg_q[33:19]};

    always_comb begin
        key_t          = kreg_q;
        key_t[19:15]   = kreg_q[19:15] ^ cnt_q;
    end

    present_inv_sbox u_key_inv_sbox (
        .din  (key_t[79:76]),
        .dout (key_top_inv)
    );

    // Undo the counter XOR and S-box, then rotate left 19 to reverse the left-61 rotation.
    assign key_rev    = {key_t[60:0], key_top_inv, key_t[75:61]};
    assign round_data = data_sinv ^ key_rev[79:16];

    // ---------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it is only seen on a rising clock edge.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (bus.start)          state_nx = ST_EXPAND;
            ST_EXPAND:        if (cnt_q == LAST_CNT)  state_nx = ST_ROUND;
            ST_ROUND:         if (cnt_q == ONE_CNT)   state_nx = ST_DONE;
            default:                                  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            pt_q   <= '0;
            kreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        data_q <= bus.ciphertext;
                        kreg_q <= bus.key;
                        cnt_q  <= ONE_CNT;
                    end
                end
                ST_EXPAND: begin
                    kreg_q <= key_fwd;
                    if (cnt_q == LAST_CNT) begin
                        // Final whitening key K_{N+1} is stripped before the first inverse round.
                        data_q <= data_q ^ key_fwd[79:16];
                    end else begin
                        cnt_q  <= cnt_q + ONE_CNT;
                    end
                end
                ST_ROUND: begin
                    data_q <= round_data;
                    kreg_q <= key_rev;
                    cnt_q  <= cnt_q - ONE_CNT;
                    if (cnt_q == ONE_CNT) begin
                        pt_q <= round_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.busy      = (state == ST_EXPAND) || (state == ST_ROUND);
    assign bus.done      = (state == ST_DONE);

endmodule
